reaction_game_ctrl: RTL and testbench

Sequencing controller for the reaction-time test datapath in `tt_um_DelosReyesJordan_HDL`. It arms a round on a start press and waits a pseudo-random delay. It then lights the GO LED, counts milliseconds until the player's button press, and publishes the result. It also detects false starts (press before GO) and timeouts, and sits between the synchronized pin inputs and the display/result logic.

---
 rtl/reaction_game_ctrl.sv | 138 +++++++++++++
 tb/tb_reaction_game_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the reaction-time game: arms on a start press, waits a
// pseudo-random delay, lights GO, measures the press latency in ms.
module reaction_game_ctrl #(
    parameter int TICK_DIV     = 10000,
    parameter int DELAY_MIN_MS = 1000,
    parameter int MAX_MS       = 9999
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ena,
    input  logic        i_start,
    input  logic        i_btn,
    output logic        o_led,
    output logic        o_busy,
    output logic [2:0]  o_state,
    output logic [13:0] o_result,
    output logic        o_result_valid,
    output logic        o_false_start,
    output logic        o_timeout
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GO    = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DELAY_MIN_MS + 2048);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]   MS_LAST   = 14'(MAX_MS - 1);
    localparam logic [13:0]   MS_MAX    = 14'(MAX_MS);

    logic [2:0]    r_state;
    logic          r_start_q;
    logic          r_btn_q;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_lfsr;
    logic [DW-1:0] r_delay;
    logic [13:0]   r_ms;
    logic [13:0]   r_result;
    logic          r_result_valid;
    logic          r_false_start;
    logic          r_timeout;

    logic          w_start_p;
    logic          w_btn_p;
    logic          w_tick;
    logic [2:0]    w_next;
    logic          w_trans;

    assign w_start_p = i_start & ~r_start_q;
    assign w_btn_p   = i_btn & ~r_btn_q;
    assign w_tick    = (r_presc == TICK_LAST);
    assign w_trans   = (w_next != r_state);

    // A press always takes priority over a coincident terminal tick.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_p) w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_btn_p)
                    w_next = ST_FAULT;
                else if (w_tick && r_delay == DW'(1))
                    w_next = ST_GO;
            end
            ST_GO: begin
                if (w_btn_p)
                    w_next = ST_DONE;
                else if (w_tick && r_ms == MS_LAST)
                    w_next = ST_FAULT;
            end
            ST_DONE, ST_FAULT: if (w_start_p) w_next = ST_WAIT;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_start_q      <= 1'b0;
            r_btn_q        <= 1'b0;
            r_presc        <= '0;
            r_lfsr         <= 16'hACE1;
            r_delay        <= '0;
            r_ms           <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_timeout      <= 1'b0;
        end else if (i_ena) begin
            r_state   <= w_next;
            r_start_q <= i_start;
            r_btn_q   <= i_btn;
            r_lfsr    <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

            if (w_trans || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + PW'(1);

            if (w_trans && w_next == ST_WAIT)
                r_delay <= DW'(DELAY_MIN_MS) + {{(DW-11){1'b0}}, r_lfsr[10:0]};
            else if (r_state == ST_WAIT && w_tick)
                r_delay <= r_delay - DW'(1);

            if (w_trans && w_next == ST_GO)
                r_ms <= '0;
            else if (r_state == ST_GO && w_tick && !w_btn_p && r_ms != MS_MAX)
                r_ms <= r_ms + 14'd1;

            // Result is captured from the pre-increment count on a press.
            if (w_trans && w_next == ST_WAIT) begin
                r_result_valid <= 1'b0;
                r_false_start  <= 1'b0;
                r_timeout      <= 1'b0;
            end else if (r_state == ST_WAIT && w_btn_p) begin
                r_false_start  <= 1'b1;
            end else if (r_state == ST_GO && w_btn_p) begin
                r_result       <= r_ms;
                r_result_valid <= 1'b1;
            end else if (r_state == ST_GO && w_tick && r_ms == MS_LAST) begin
                r_result       <= MS_MAX;
                r_timeout      <= 1'b1;
            end
        end
    end

    assign o_state        = r_state;
    assign o_led          = (r_state == ST_GO);
    assign o_busy         = (r_state == ST_WAIT) || (r_state == ST_GO);
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_false_start  = r_false_start;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl with small timing
// parameters so complete rounds fit in a few thousand cycles.
module tb_reaction_game_ctrl;

   localparam int TICK_DIV     = 4;
   localparam int DELAY_MIN_MS = 2;
   localparam int MAX_MS       = 50;
   localparam int LED_BOUND    = (DELAY_MIN_MS + 2048) * TICK_DIV + 20;

   logic        clock;
   logic        resetN;
   logic        ena;
   logic        startBtn;
   logic        reactBtn;
   logic        led;
   logic        busy;
   logic [2:0]  state;
   logic [13:0] result;
   logic        resultValid;
   logic        falseStart;
   logic        timeoutFlag;

   logic [15:0] modelLfsr;
   int          checkCount;
   int          passCount;
   int          expDelay;
   int          waitLen;
   logic        ledSeen;

   reaction_game_ctrl #(
      .TICK_DIV    (TICK_DIV),
      .DELAY_MIN_MS(DELAY_MIN_MS),
      .MAX_MS      (MAX_MS)
   ) dut (
      .i_clk         (clock),
      .i_rst_n       (resetN),
      .i_ena         (ena),
      .i_start       (startBtn),
      .i_btn         (reactBtn),
      .o_led         (led),
      .o_busy        (busy),
      .o_state       (state),
      .o_result      (result),
      .o_result_valid(resultValid),
      .o_false_start (falseStart),
      .o_timeout     (timeoutFlag)
   );

   // Free-running 10-unit clock with the first rising edge at time 5.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference Galois LFSR, advanced on every enabled rising edge.
   always @(posedge clock or negedge resetN) begin
      if (!resetN)
         modelLfsr <= 16'hACE1;
      else if (ena)
         modelLfsr <= {1'b0, modelLfsr[15:1]} ^ (modelLfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Compares one observed value with its expected value and tallies it.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
   endtask

   // Drives both buttons for the next rising edge and advances to the following falling edge.
   task automatic applyStimulus(input logic s, input logic b);
      startBtn = s;
      reactBtn = b;
      @(negedge clock);
   endtask

   // Counts falling edges until the GO indicator lights, bounded so a stuck DUT cannot hang the run.
   task automatic waitForLed(output int cycles);
      cycles = 0;
      while (!led && cycles < LED_BOUND) begin
         @(negedge clock);
         cycles++;
      end
      checkOutput("led rose within bound", {31'b0, led}, 32'd1);
   endtask

   // Starts a round from the current negedge and returns with the DUT in its first WAIT cycle.
   task automatic armRound();
      expDelay = DELAY_MIN_MS + int'(modelLfsr[10:0]);
      applyStimulus(1'b1, reactBtn);
      startBtn = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      resetN     = 1'b1;
      ena        = 1'b1;
      startBtn   = 1'b0;
      reactBtn   = 1'b0;

      #3 resetN = 1'b0;
      #1;
      checkOutput("reset state", {29'b0, state}, 32'd0);
      checkOutput("reset led", {31'b0, led}, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset result", {18'b0, result}, 32'd0);
      checkOutput("reset flags", {29'b0, resultValid, falseStart, timeoutFlag}, 32'd0);
      repeat (3) @(negedge clock);
      resetN = 1'b1;
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle ignores btn", {29'b0, state}, 32'd0);
      reactBtn = 1'b0;
      @(negedge clock);

      // Normal round: press exactly 37 ms after GO.
      armRound();
      checkOutput("normal wait entry state", {29'b0, state}, 32'd1);
      checkOutput("normal wait busy", {31'b0, busy}, 32'd1);
      waitForLed(waitLen);
      checkOutput("normal wait length", waitLen, expDelay * TICK_DIV);
      checkOutput("normal go state", {29'b0, state}, 32'd2);
      repeat (37 * TICK_DIV) @(negedge clock);
      applyStimulus(1'b0, 1'b1);
      checkOutput("normal done state", {29'b0, state}, 32'd3);
      checkOutput("normal result", {18'b0, result}, 32'd37);
      checkOutput("normal result valid", {31'b0, resultValid}, 32'd1);
      checkOutput("normal led off", {31'b0, led}, 32'd0);
      checkOutput("normal busy off", {31'b0, busy}, 32'd0);
      reactBtn = 1'b0;
      @(negedge clock);

      // Re-arm from DONE, then false start three cycles into WAIT.
      armRound();
      checkOutput("rearm state", {29'b0, state}, 32'd1);
      checkOutput("rearm flags cleared", {29'b0, resultValid, falseStart, timeoutFlag}, 32'd0);
      checkOutput("rearm result held", {18'b0, result}, 32'd37);
      ledSeen = led;
      repeat (2) begin
         @(negedge clock);
         ledSeen = ledSeen | led;
      end
      applyStimulus(1'b0, 1'b1);
      ledSeen = ledSeen | led;
      checkOutput("false start state", {29'b0, state}, 32'd4);
      checkOutput("false start flag", {31'b0, falseStart}, 32'd1);
      checkOutput("false start valid", {31'b0, resultValid}, 32'd0);
      checkOutput("false start led never", {31'b0, ledSeen}, 32'd0);
      checkOutput("false start result held", {18'b0, result}, 32'd37);
      reactBtn = 1'b0;
      @(negedge clock);

      // Timeout round from FAULT.
      armRound();
      checkOutput("timeout round arm", {29'b0, state}, 32'd1);
      waitForLed(waitLen);
      checkOutput("timeout wait length", waitLen, expDelay * TICK_DIV);
      repeat (MAX_MS * TICK_DIV - 1) @(negedge clock);
      checkOutput("still go before timeout", {29'b0, state}, 32'd2);
      @(negedge clock);
      checkOutput("timeout state", {29'b0, state}, 32'd4);
      checkOutput("timeout flag", {31'b0, timeoutFlag}, 32'd1);
      checkOutput("timeout result", {18'b0, result}, 32'd50);
      checkOutput("timeout no valid", {31'b0, resultValid}, 32'd0);

      // Press coincident with the fifth-to-sixth ms tick.
      armRound();
      waitForLed(waitLen);
      repeat (5 * TICK_DIV + TICK_DIV - 1) @(negedge clock);
      applyStimulus(1'b0, 1'b1);
      checkOutput("coincident state", {29'b0, state}, 32'd3);
      checkOutput("coincident result", {18'b0, result}, 32'd5);
      reactBtn = 1'b0;
      @(negedge clock);

      // Start and btn rise together in DONE; btn then stays held into GO.
      expDelay = DELAY_MIN_MS + int'(modelLfsr[10:0]);
      applyStimulus(1'b1, 1'b1);
      startBtn = 1'b0;
      checkOutput("start+btn goes wait", {29'b0, state}, 32'd1);
      checkOutput("start+btn no false start", {31'b0, falseStart}, 32'd0);
      waitForLed(waitLen);
      checkOutput("held btn wait length", waitLen, expDelay * TICK_DIV);
      repeat (10) @(negedge clock);
      checkOutput("held btn no capture", {29'b0, state}, 32'd2);
      checkOutput("held btn no valid", {31'b0, resultValid}, 32'd0);

      // Freeze for 20 cycles in GO; the frozen cycles must not count.
      reactBtn = 1'b0;
      ena      = 1'b0;
      repeat (20) @(negedge clock);
      checkOutput("freeze state", {29'b0, state}, 32'd2);
      checkOutput("freeze led", {31'b0, led}, 32'd1);
      ena = 1'b1;
      repeat (38) @(negedge clock);
      applyStimulus(1'b0, 1'b1);
      checkOutput("freeze resume state", {29'b0, state}, 32'd3);
      checkOutput("freeze resume result", {18'b0, result}, 32'd12);
      reactBtn = 1'b0;
      @(negedge clock);

      // Asynchronous reset in the middle of a GO phase.
      armRound();
      waitForLed(waitLen);
      repeat (3) @(negedge clock);
      #2 resetN = 1'b0;
      #1;
      checkOutput("midround reset state", {29'b0, state}, 32'd0);
      checkOutput("midround reset led", {31'b0, led}, 32'd0);
      checkOutput("midround reset busy", {31'b0, busy}, 32'd0);
      checkOutput("midround reset result", {18'b0, result}, 32'd0);
      checkOutput("midround reset flags", {29'b0, resultValid, falseStart, timeoutFlag}, 32'd0);
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      armRound();
      checkOutput("restart from idle", {29'b0, state}, 32'd1);
      waitForLed(waitLen);
      checkOutput("restart wait length", waitLen, expDelay * TICK_DIV);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
